// File: rtl/booth_mul_arbiter.sv
// Round-robin arbiter sharing one 4x4 signed booth multiplier among NREQ requesters,
// with operand hold during the multiply and a watchdog that aborts a stuck operation.
module booth_mul_arbiter #(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NREQ-1:0]     req_valid,
   input  logic [4*NREQ-1:0]   req_x,
   input  logic [4*NREQ-1:0]   req_y,
   output logic [NREQ-1:0]     req_ready,
   output logic [NREQ-1:0]     resp_valid,
   output logic [7:0]          resp_z,
   output logic                resp_err,
   output logic                busy,
   output logic                err_timeout,
   input  logic                err_clr,
   output logic                mul_start,
   output logic [3:0]          mul_x,
   output logic [3:0]          mul_y,
   input  logic                mul_valid,
   input  logic [7:0]          mul_z
);

   localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   state_t          state;
   logic [GW-1:0]   last_grant;
   logic [GW-1:0]   gnt;
   logic            found;
   logic [4:0]      timer;

   // Scan from the requester after the last winner, wrapping around.
   always_comb begin
      int j;
      j     = 0;
      found = 1'b0;
      gnt   = '0;
      for (int k = 1; k <= NREQ; k++) begin
         j = int'(last_grant) + k;
         if (j >= NREQ) j = j - NREQ;
         if (!found && req_valid[j]) begin
            found = 1'b1;
            gnt   = GW'(j);
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (state == IDLE && found) req_ready[gnt] = 1'b1;
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         last_grant  <= GW'(NREQ - 1);
         timer       <= '0;
         resp_valid  <= '0;
         resp_z      <= '0;
         resp_err    <= 1'b0;
         err_timeout <= 1'b0;
         mul_start   <= 1'b0;
         mul_x       <= '0;
         mul_y       <= '0;
      end else begin
         resp_valid <= '0;
         resp_err   <= 1'b0;
         // A timeout later in this block overrides the clear.
         if (err_clr) err_timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (found) begin
                  mul_x      <= req_x[4*int'(gnt) +: 4];
                  mul_y      <= req_y[4*int'(gnt) +: 4];
                  last_grant <= gnt;
                  mul_start  <= 1'b1;
                  state      <= ISSUE;
               end
            end
            ISSUE: begin
               mul_start <= 1'b0;
               timer     <= '0;
               state     <= WAIT;
            end
            WAIT: begin
               // mul_x/mul_y stay untouched: the multiplier re-reads X every iteration.
               if (mul_valid) begin
                  resp_z                 <= mul_z;
                  resp_valid[last_grant] <= 1'b1;
                  state                  <= IDLE;
               end else if (timer == 5'(TIMEOUT - 1)) begin
                  resp_z                 <= '0;
                  resp_valid[last_grant] <= 1'b1;
                  resp_err               <= 1'b1;
                  err_timeout            <= 1'b1;
                  state                  <= IDLE;
               end else begin
                  timer <= timer + 5'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Directed bench for booth_mul_arbiter with a behavioural multiplier of programmable latency.
module tb_booth_mul_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req_valid;
   logic [15:0] req_x, req_y;
   logic [3:0]  req_ready, resp_valid;
   logic [7:0]  resp_z;
   logic        resp_err, busy, err_timeout, err_clr;
   logic        mul_start;
   logic [3:0]  mul_x, mul_y;
   logic        mul_valid;
   logic [7:0]  mul_z;

   int cmp_cnt = 0;
   int err_cnt = 0;
   int mul_delay = 5;

   always #5 clk = ~clk;

   booth_mul_arbiter #(.NREQ(4), .TIMEOUT(16)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
      .req_ready(req_ready), .resp_valid(resp_valid), .resp_z(resp_z), .resp_err(resp_err),
      .busy(busy), .err_timeout(err_timeout), .err_clr(err_clr), .mul_start(mul_start),
      .mul_x(mul_x), .mul_y(mul_y), .mul_valid(mul_valid), .mul_z(mul_z)
   );

   // Multiplier stand-in: mul_valid mul_delay cycles after the start cycle (0 = never).
   // The product uses the operands present at completion, so unstable operands show up.
   logic [4:0]        mcnt;
   logic signed [7:0] mx8, my8;
   assign mx8       = {{4{mul_x[3]}}, mul_x};
   assign my8       = {{4{mul_y[3]}}, mul_y};
   assign mul_z     = mx8 * my8;
   assign mul_valid = (mcnt == 5'd1);
   always @(posedge clk or negedge rst) begin
      if (!rst)               mcnt <= '0;
      else if (mul_start)     mcnt <= 5'(mul_delay);
      else if (mcnt != 5'd0)  mcnt <= mcnt - 5'd1;
   end

   // Steps to the next negedge until a response appears; c counts cycles stepped.
   task automatic wait_resp(output int c);
      c = 0;
      do begin
         @(negedge clk);
         c++;
      end while (resp_valid == 4'd0 && c < 40);
   endtask

   task automatic test_reset();
      rst = 1'b0; req_valid = '0; req_x = '0; req_y = '0; err_clr = 1'b0;
      @(negedge clk);
      cmp_cnt++;
      if ({busy, mul_start, mul_x, mul_y, resp_valid, resp_z, resp_err, err_timeout, req_ready} !== '0) begin
         err_cnt++;
         $display("FAIL reset_outputs: busy=%b start=%b x=%h y=%h rv=%b z=%h re=%b et=%b rdy=%b, required all 0",
                  busy, mul_start, mul_x, mul_y, resp_valid, resp_z, resp_err, err_timeout, req_ready);
      end
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single();
      int c;
      req_valid = 4'b0001; req_x[3:0] = 4'd3; req_y[3:0] = 4'hE;
      #1;
      cmp_cnt++;
      if (req_ready !== 4'b0001) begin
         err_cnt++; $display("FAIL single_ready: got %b, required 0001", req_ready);
      end
      @(negedge clk); req_valid = '0;
      cmp_cnt++;
      if (mul_start !== 1'b1 || mul_x !== 4'd3 || mul_y !== 4'hE) begin
         err_cnt++; $display("FAIL single_issue: start=%b x=%h y=%h, required 1 3 e", mul_start, mul_x, mul_y);
      end
      @(negedge clk);
      cmp_cnt++;
      if (mul_start !== 1'b0) begin
         err_cnt++; $display("FAIL single_start_width: start=%b in wait, required 0", mul_start);
      end
      wait_resp(c);
      cmp_cnt++;
      if (c + 2 !== 7) begin
         err_cnt++; $display("FAIL single_latency: response %0d cycles after handshake, required 7", c + 2);
      end
      cmp_cnt++;
      if (resp_valid !== 4'b0001 || resp_z !== 8'hFA || resp_err !== 1'b0) begin
         err_cnt++; $display("FAIL single_result: rv=%b z=%h err=%b, required 0001 fa 0", resp_valid, resp_z, resp_err);
      end
      @(negedge clk);
      cmp_cnt++;
      if (busy !== 1'b0 || resp_valid !== 4'd0) begin
         err_cnt++; $display("FAIL single_after: busy=%b rv=%b, required 0 0000", busy, resp_valid);
      end
   endtask

   task automatic test_hold();
      int c;
      bit bad;
      bad = 0;
      req_valid = 4'b0100; req_x[11:8] = 4'h8; req_y[11:8] = 4'h7;
      #1;
      cmp_cnt++;
      if (req_ready !== 4'b0100) begin
         err_cnt++; $display("FAIL hold_ready: got %b, required 0100", req_ready);
      end
      @(negedge clk);
      req_valid = '0; req_x = 16'h5A3F; req_y = 16'hC01E;
      c = 0;
      while (resp_valid == 4'd0 && c < 40) begin
         if (mul_x !== 4'h8 || mul_y !== 4'h7) bad = 1;
         @(negedge clk); c++;
      end
      cmp_cnt++;
      if (bad) begin
         err_cnt++; $display("FAIL hold_operands: operands changed during multiply, required 8/7 throughout");
      end
      cmp_cnt++;
      if (resp_valid !== 4'b0100 || resp_z !== 8'hC8 || resp_err !== 1'b0) begin
         err_cnt++; $display("FAIL hold_result: rv=%b z=%h err=%b, required 0100 c8 0", resp_valid, resp_z, resp_err);
      end
   endtask

   task automatic test_round_robin();
      int exp_g [7] = '{0, 1, 2, 3, 1, 3, 3};
      logic [3:0] g1h;
      int c;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         req_x[4*i +: 4] = 4'(i + 1);
         req_y[4*i +: 4] = 4'd2;
      end
      req_valid = 4'b1111;
      @(negedge clk); rst = 1'b1;
      for (int n = 0; n < 7; n++) begin
         if (n == 4) req_valid = 4'b1010;
         if (n == 6) req_valid = 4'b1000;
         #1;
         c = 0;
         while (req_ready == 4'd0 && c < 40) begin @(negedge clk); c++; #1; end
         g1h = 4'b0001 << exp_g[n];
         cmp_cnt++;
         if (req_ready !== g1h) begin
            err_cnt++; $display("FAIL rr_grant%0d: got %b, required %b", n, req_ready, g1h);
         end
         @(negedge clk);
         wait_resp(c);
         cmp_cnt++;
         if (resp_valid !== g1h || resp_z !== 8'(2 * (exp_g[n] + 1))) begin
            err_cnt++; $display("FAIL rr_resp%0d: rv=%b z=%h, required %b %h", n, resp_valid, resp_z,
                                g1h, 8'(2 * (exp_g[n] + 1)));
         end
      end
      req_valid = '0;
      @(negedge clk);
   endtask

   task automatic test_timeout();
      int c;
      mul_delay = 0;
      req_valid = 4'b0001; req_x[3:0] = 4'd1; req_y[3:0] = 4'd1;
      @(negedge clk); req_valid = '0;
      wait_resp(c);
      cmp_cnt++;
      if (c + 1 !== 18) begin
         err_cnt++; $display("FAIL timeout_latency: response %0d cycles after handshake, required 18", c + 1);
      end
      cmp_cnt++;
      if (resp_valid !== 4'b0001 || resp_z !== 8'h00 || resp_err !== 1'b1 || err_timeout !== 1'b1) begin
         err_cnt++; $display("FAIL timeout_resp: rv=%b z=%h re=%b et=%b, required 0001 00 1 1",
                             resp_valid, resp_z, resp_err, err_timeout);
      end
      mul_delay = 5;
      @(negedge clk);
      req_valid = 4'b0010; req_x[7:4] = 4'd2; req_y[7:4] = 4'd3;
      @(negedge clk); req_valid = '0;
      wait_resp(c);
      cmp_cnt++;
      if (resp_valid !== 4'b0010 || resp_z !== 8'h06 || resp_err !== 1'b0 || err_timeout !== 1'b1) begin
         err_cnt++; $display("FAIL timeout_sticky: rv=%b z=%h re=%b et=%b, required 0010 06 0 1",
                             resp_valid, resp_z, resp_err, err_timeout);
      end
      err_clr = 1'b1;
      @(negedge clk); err_clr = 1'b0;
      cmp_cnt++;
      if (err_timeout !== 1'b0) begin
         err_cnt++; $display("FAIL timeout_clear: et=%b, required 0", err_timeout);
      end
   endtask

   task automatic test_expiry_race();
      int c;
      mul_delay = 16;
      req_valid = 4'b0100; req_x[11:8] = 4'hF; req_y[11:8] = 4'hF;
      @(negedge clk); req_valid = '0;
      wait_resp(c);
      cmp_cnt++;
      if (c + 1 !== 18 || resp_valid !== 4'b0100 || resp_z !== 8'h01 || resp_err !== 1'b0 || err_timeout !== 1'b0) begin
         err_cnt++; $display("FAIL race_result: lat=%0d rv=%b z=%h re=%b et=%b, required 18 0100 01 0 0",
                             c + 1, resp_valid, resp_z, resp_err, err_timeout);
      end
      mul_delay = 5;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int seen;
      int c;
      seen = 0;
      req_valid = 4'b0001; req_x[3:0] = 4'd1; req_y[3:0] = 4'd2;
      @(negedge clk); req_valid = '0;
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      #1;
      cmp_cnt++;
      if ({busy, mul_start, mul_x, mul_y, resp_valid, resp_z, resp_err, err_timeout} !== '0) begin
         err_cnt++; $display("FAIL midreset_outputs: busy=%b x=%h y=%h rv=%b z=%h, required all 0",
                             busy, mul_x, mul_y, resp_valid, resp_z);
      end
      @(negedge clk); @(negedge clk); rst = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (resp_valid !== 4'd0) seen++;
      end
      cmp_cnt++;
      if (seen !== 0) begin
         err_cnt++; $display("FAIL midreset_noresp: %0d response cycles, required 0", seen);
      end
      req_valid = 4'b0001; req_x[3:0] = 4'd2; req_y[3:0] = 4'hD;
      #1;
      cmp_cnt++;
      if (req_ready !== 4'b0001) begin
         err_cnt++; $display("FAIL midreset_ready: got %b, required 0001", req_ready);
      end
      @(negedge clk); req_valid = '0;
      wait_resp(c);
      cmp_cnt++;
      if (resp_valid !== 4'b0001 || resp_z !== 8'hFA || resp_err !== 1'b0) begin
         err_cnt++; $display("FAIL midreset_result: rv=%b z=%h err=%b, required 0001 fa 0", resp_valid, resp_z, resp_err);
      end
      @(negedge clk);
   endtask

   task automatic test_cancel();
      int resp_cnt;
      int bad;
      resp_cnt = 0; bad = 0;
      req_valid = 4'b0001; req_x[3:0] = 4'd1; req_y[3:0] = 4'd1;
      @(negedge clk); req_valid = '0;
      for (int i = 1; i < 25; i++) begin
         if (i == 2) req_valid = 4'b0010;
         if (i == 3) req_valid = 4'b0000;
         #1;
         if (req_ready !== 4'd0) bad++;
         if (resp_valid !== 4'd0) begin
            resp_cnt++;
            if (resp_valid !== 4'b0001 || resp_z !== 8'h01) bad++;
         end
         @(negedge clk);
      end
      cmp_cnt++;
      if (resp_cnt !== 1) begin
         err_cnt++; $display("FAIL cancel_resp_count: %0d responses, required 1", resp_cnt);
      end
      cmp_cnt++;
      if (bad !== 0) begin
         err_cnt++; $display("FAIL cancel_onehot: %0d bad ready/response cycles, required 0", bad);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_hold();
      test_round_robin();
      test_timeout();
      test_expiry_race();
      test_reset_mid();
      test_cancel();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/booth_mul_arbiter.md
Name: booth_mul_arbiter

Overview:
- Shares one 4x4 signed booth multiplier (start/valid interface, 8-bit signed product) among NREQ requesters.
- Per requester: valid/ready request handshake and a one-cycle response pulse.
- Round-robin arbitration; operands are latched and held stable for the whole multiply.
- Watchdog aborts an operation that never returns mul_valid.
- Sits between client blocks and the multiplier instance; drives its start, X and Y; shares clk/rst with it.

Parameters:
NREQ, 4, number of requesters (2..8)
TIMEOUT, 16, max WAIT cycles without mul_valid before abort (6..31; timer 5 bits)

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-low
req_valid  input  NREQ  request i has operands pending
req_x  input  4*NREQ  signed multiplicand per requester, slice i = [4i+3:4i]
req_y  input  4*NREQ  signed multiplier per requester, same slicing
req_ready  output  NREQ  handshake accept, one-hot, combinational
resp_valid  output  NREQ  one-cycle result pulse to requester i, one-hot
resp_z  output  8  signed product (valid with resp_valid)
resp_err  output  1  high with resp_valid when result aborted by timeout
busy  output  1  state != IDLE
err_timeout  output  1  sticky timeout flag
err_clr  input  1  synchronous clear of err_timeout
mul_start  output  1  start pulse to multiplier
mul_x  output  4  operand X to multiplier
mul_y  output  4  operand Y to multiplier
mul_valid  input  1  multiplier done pulse
mul_z  input  8  multiplier product

Behaviour:
- Reset (async, rst=0), all values take effect immediately:
  - state=IDLE; all registered outputs 0 (resp_valid, resp_z, resp_err, err_timeout, mul_start, mul_x, mul_y).
  - Round-robin pointer last_grant=NREQ-1, so requester 0 has first priority.
  - Timer=0.
  - The multiplier is reset by the same rst; mid-operation reset abandons the transaction with no response.
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - If any req_valid: g = first set bit scanning from last_grant+1 upward, wrapping.
  - req_ready[g]=1 combinationally this cycle; handshake completes.
  - At the clock edge: latch req_x/req_y slice g into mul_x/mul_y; last_grant<=g; state->ISSUE.
  - No req_valid: stay; req_ready all 0.
- ISSUE: mul_start=1 for exactly this cycle; clear timer; ->WAIT.
- WAIT:
  - mul_start=0; mul_x/mul_y held constant, because the multiplier samples X bits every iteration.
  - mul_valid=1: next edge resp_z<=mul_z, resp_valid[g]<=1 for one cycle, resp_err<=0; ->IDLE.
  - Else timer+1; when timer reaches TIMEOUT-1 without mul_valid:
    - resp_valid[g]<=1, resp_z<=0, resp_err<=1, err_timeout<=1; ->IDLE.
  - mul_valid and expiry in the same cycle: mul_valid wins, no error.
- mul_valid outside WAIT: ignored.
- Requester rules: must hold req_valid and operands stable until req_ready. Dropping req_valid before ready cancels the request with no side effects. Operands after the handshake are don't-care.
- Back-to-back: the cycle resp_valid is high, the block is in IDLE and may accept the next request.
- Latency with the team multiplier: handshake cycle T, ISSUE T+1, mul_valid at T+6, resp_valid at T+7. Throughput one product per 7 cycles.
- err_clr clears err_timeout next edge. A timeout in the same cycle as err_clr sets the flag (set wins).
- Product is passed through unmodified; no saturation or width changes.

Test Plan:
- Req0 x=3 y=-2, single request -> req_ready[0] in handshake cycle; mul_start one cycle later; resp_valid[0]=1 exactly 7 cycles after handshake with resp_z=8'hFA, resp_err=0, busy low the following cycle.
- Req2 x=-8 y=7 -> resp_z=8'hC8 on resp_valid[2]. Verify mul_x/mul_y remain 4'h8/4'h7 through all of WAIT even when req_x/req_y change after handshake.
- All four req_valid held from reset, each hi constant -> grants 0,1,2,3 in order. Then req1 and req3 only -> grant 1 then 3. Then only req3 -> 3 again, no starvation.
- Multiplier stubbed, mul_valid never asserted -> resp_valid[g] with resp_z=0, resp_err=1 after 16 WAIT cycles. err_timeout sticky through the next normal transaction; err_clr clears it. Separate case: mul_valid on the expiry cycle -> normal result, no error.
- rst low during WAIT -> all outputs 0 immediately, no resp_valid after release; next request from requester 0 completes normally.
- req_valid[1] pulsed one cycle while the block is busy -> never granted, no response; resp_valid stays one-hot at all times.
